// File: rtl/attract_screen.sv
// Attract-mode grid generator: random tile, sweep, cascade or blank, rewritten every FRAME_DELAY vsyncs.
// Optional macro ATTRACT_RETRY_CAP_EN bounds mode-0 resampling to RETRY_MAX rejected samples.
module attract_screen #(
    parameter int GRID_CELLS  = 16,
    parameter int CELL_BITS   = 4,
    parameter int FRAME_DELAY = 30,
    parameter int TILE_VALUE  = 11,
    parameter int LFSR_W      = 4,
    parameter int RETRY_MAX   = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic [1:0]                      mode,
    input  logic                            vsync_rising_edge,
    input  logic [LFSR_W-1:0]               lfsr_out,
    output logic [GRID_CELLS*CELL_BITS-1:0] grid,
    output logic                            update_pulse
);
    localparam int GW = GRID_CELLS * CELL_BITS;
    localparam int RW = (RETRY_MAX < 2) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [7:0]           FD    = 8'(FRAME_DELAY);
    localparam logic [LFSR_W:0]      CELLS = (LFSR_W + 1)'(GRID_CELLS);
    localparam logic [LFSR_W-1:0]    LAST  = LFSR_W'(GRID_CELLS - 1);
    localparam logic [CELL_BITS-1:0] TILE  = CELL_BITS'(TILE_VALUE);
    localparam logic [RW-1:0]        RMAX  = RW'(RETRY_MAX);
`ifdef ATTRACT_RETRY_CAP_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_WAIT} state_t;

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_cnt, w_cnt_nxt;
    logic [LFSR_W-1:0] r_pos, w_pos_nxt, w_pos_inc, w_pos_new;
    logic [3:0]        r_phase, w_phase_nxt;
    logic [1:0]        r_mode, w_mode_nxt;
    logic [GW-1:0]     r_grid, w_grid_nxt, w_cascade;
    logic              r_pulse, w_pulse_nxt;
    logic [RW-1:0]     r_rej, w_rej_nxt;
    logic              w_changed, w_in_range, w_accept, w_force, w_done;

    // A mode switch relaxes the "must move" rule so the first random tile may land on the old pos.
    assign w_changed  = (mode != r_mode);
    assign w_in_range = ({1'b0, lfsr_out} < CELLS);
    assign w_accept   = w_in_range && (w_changed || (lfsr_out != r_pos));
    assign w_force    = CAP_EN && !w_accept && (r_rej == RMAX);
    assign w_done     = (r_state == S_UPDATE) && ((mode != 2'd0) || w_accept || w_force);
    assign w_pos_inc  = (r_pos == LAST) ? '0 : r_pos + 1'b1;

    always_comb begin
        w_cascade = '0;
        for (int i = 0; i < GRID_CELLS; i++) begin
            w_cascade[i*CELL_BITS +: CELL_BITS] = CELL_BITS'((i + int'(r_phase)) % 11 + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   w_state_nxt = S_UPDATE;
                S_UPDATE: if (w_done) w_state_nxt = S_WAIT;
                S_WAIT:   if (r_cnt == FD) w_state_nxt = S_UPDATE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_grid_nxt  = r_grid;
        w_pulse_nxt = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_pos_nxt   = r_pos;
        w_phase_nxt = r_phase;
        w_mode_nxt  = r_mode;
        w_rej_nxt   = r_rej;
        w_pos_new   = '0;
        if (!enable) begin
            w_grid_nxt = '0;
            w_cnt_nxt  = FD;
            w_rej_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_grid_nxt = '0;
                    w_cnt_nxt  = FD;
                end
                S_WAIT: begin
                    if (vsync_rising_edge && (r_cnt < FD)) w_cnt_nxt = r_cnt + 8'd1;
                end
                S_UPDATE: begin
                    if (w_done) begin
                        w_pulse_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                        w_mode_nxt  = mode;
                        w_rej_nxt   = '0;
                        w_grid_nxt  = '0;
                        case (mode)
                            2'd0: begin
                                w_pos_new  = w_accept ? lfsr_out : w_pos_inc;
                                w_pos_nxt  = w_pos_new;
                                w_grid_nxt[int'(w_pos_new)*CELL_BITS +: CELL_BITS] = TILE;
                            end
                            2'd1: begin
                                w_pos_new  = w_changed ? '0 : w_pos_inc;
                                w_pos_nxt  = w_pos_new;
                                w_grid_nxt[int'(w_pos_new)*CELL_BITS +: CELL_BITS] = TILE;
                            end
                            2'd2: begin
                                w_grid_nxt  = w_cascade;
                                w_phase_nxt = (r_phase == 4'd10) ? 4'd0 : r_phase + 4'd1;
                            end
                            default: w_grid_nxt = '0;
                        endcase
                    end else if (CAP_EN) begin
                        w_rej_nxt = r_rej + 1'b1;
                    end
                end
                default: w_grid_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grid  <= '0;
            r_pulse <= 1'b0;
            r_cnt   <= FD;
            r_pos   <= '0;
            r_phase <= '0;
            r_mode  <= '0;
            r_rej   <= '0;
        end else begin
            r_grid  <= w_grid_nxt;
            r_pulse <= w_pulse_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pos   <= w_pos_nxt;
            r_phase <= w_phase_nxt;
            r_mode  <= w_mode_nxt;
            r_rej   <= w_rej_nxt;
        end
    end

    assign grid         = r_grid;
    assign update_pulse = r_pulse;
endmodule
